// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage:
// FSM state encoding, NOP bubble encoding, word width and reset PC.
package fetch_stage_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  // Sequential PC increment; wraps naturally modulo 2^32.
  function automatic logic [WORD_W-1:0] pc_incr(input logic [WORD_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold and bubble controls.
// Priority: reset, bubble, hold, load.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic [WORD_W-1:0] instr_d,
  input  logic [WORD_W-1:0] pc_plus4_d,
  output logic [WORD_W-1:0] instr_q,
  output logic [WORD_W-1:0] pc_plus4_q,
  output logic              valid_q
);

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!hold) begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/stall control FSM and IF/ID register.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall_Pc,
  input  logic              IF_ID_RegStall,
  input  logic              flush,
  input  logic              MEM_PCSrc,
  input  logic              MEM_PCSrc_b,
  input  logic [WORD_W-1:0] MEM_BranchTarget,
  input  logic [WORD_W-1:0] MEM_JumpTarget,
  input  logic [WORD_W-1:0] IMem_Instr,
  output logic [WORD_W-1:0] IMem_Addr,
  output logic [WORD_W-1:0] ID_Instr,
  output logic [WORD_W-1:0] ID_PCPlus4,
  output logic              ID_Valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [WORD_W-1:0] Stall_Cycles,
  output logic [WORD_W-1:0] Flush_Cycles,
`endif
  output logic [1:0]        dbg_state
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] pc_plus4;
  logic              redirect;
  logic              stall_eff;
  logic              id_bubble;

  assign pc_plus4  = pc_incr(pc_q);
  assign redirect  = MEM_PCSrc | MEM_PCSrc_b;
  // A redirect always moves the PC, so it cancels a concurrent PC stall.
  assign stall_eff = Stall_Pc & ~redirect;
  // Without an IF/ID hold, a stalled PC would re-present the same instruction;
  // inject a bubble so it is issued only once.
  assign id_bubble = flush | (stall_eff & ~IF_ID_RegStall);

  assign IMem_Addr = pc_q;
  assign dbg_state = state_q;

  always_comb begin
    pc_d    = pc_plus4;
    state_d = FS_RUN;
    if (MEM_PCSrc_b) begin
      pc_d = MEM_JumpTarget;
    end else if (MEM_PCSrc) begin
      pc_d = MEM_BranchTarget;
    end else if (Stall_Pc) begin
      pc_d    = pc_q;
      state_d = FS_HOLD;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_q    <= RESET_PC;
      state_q <= FS_BOOT;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (Clk),
    .rst_n      (Rst),
    .hold       (IF_ID_RegStall),
    .bubble     (id_bubble),
    .instr_d    (IMem_Instr),
    .pc_plus4_d (pc_plus4),
    .instr_q    (ID_Instr),
    .pc_plus4_q (ID_PCPlus4),
    .valid_q    (ID_Valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Stall_Cycles <= '0;
      Flush_Cycles <= '0;
    end else begin
      if (stall_eff && (Stall_Cycles != '1)) Stall_Cycles <= Stall_Cycles + 32'd1;
      if (flush && (Flush_Cycles != '1))     Flush_Cycles <= Flush_Cycles + 32'd1;
    end
  end
`endif

endmodule
